// File: rtl/viterbi_ber_monitor.sv
// Post-decoder BER monitor: finds the decoder latency against the encoder input, then counts bits/errors.
// Optional loss-of-lock detection is enabled by defining BER_LOSS_EN.
module viterbi_ber_monitor #(
   parameter int MAX_LAT  = 64,
   parameter int LOCK_WIN = 32,
   parameter int LOCK_THR = 2,
   parameter int LOSS_THR = 8,
   parameter int CNT_W    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tx_valid_i,
   input  logic                       tx_bit_i,
   input  logic                       rx_valid_i,
   input  logic                       rx_bit_i,
   input  logic                       clear_i,
   output logic                       locked_o,
   output logic [$clog2(MAX_LAT)-1:0] latency_o,
   output logic [CNT_W-1:0]           bit_ct_o,
   output logic [CNT_W-1:0]           err_ct_o,
   output logic                       sat_o
);

   localparam int LAT_W = $clog2(MAX_LAT);
   localparam int WIN_W = $clog2(LOCK_WIN + 1);
`ifdef BER_LOSS_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic logic [WIN_W-1:0] win_err_add(input logic [WIN_W-1:0] acc,
                                                    input logic             inc);
      if (acc == WIN_W'(LOCK_WIN)) return acc;
      return acc + WIN_W'(inc);
   endfunction

   function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] acc,
                                                input logic             inc);
      if (&acc) return acc;
      return acc + CNT_W'(inc);
   endfunction

   logic [MAX_LAT-1:0] hist_p1;
   state_t             state_p1, state_p0;
   logic [LAT_W-1:0]   lat_p1, lat_p0;
   logic [WIN_W-1:0]   win_cnt_p1, win_err_p1, win_err_p0;
   logic [CNT_W-1:0]   bit_ct_p1, err_ct_p1, bit_ct_p0, err_ct_p0;
   logic               sat_p1;
   logic               ref_bit_p0, mism_p0, win_close_p0, count_p0;

   // Stage p0: compare against history tap selected by the current trial latency
   assign ref_bit_p0   = hist_p1[lat_p1];
   assign mism_p0      = rx_valid_i & (rx_bit_i ^ ref_bit_p0);
   assign win_err_p0   = win_err_add(win_err_p1, mism_p0);
   assign win_close_p0 = rx_valid_i && (win_cnt_p1 == WIN_W'(LOCK_WIN - 1));
   assign count_p0     = (state_p1 == LOCKED) && rx_valid_i;
   assign bit_ct_p0    = cnt_add(bit_ct_p1, 1'b1);
   assign err_ct_p0    = cnt_add(err_ct_p1, mism_p0);

   always_comb begin
      state_p0 = state_p1;
      lat_p0   = lat_p1;
      case (state_p1)
         SEARCH: begin
            if (win_close_p0) begin
               if (win_err_p0 <= WIN_W'(LOCK_THR)) state_p0 = LOCKED;
               else                                lat_p0   = lat_p1 + LAT_W'(1);
            end
         end
         LOCKED: begin
            if (LOSS_EN && win_close_p0 && (win_err_p0 > WIN_W'(LOSS_THR))) begin
               state_p0 = SEARCH;
               lat_p0   = '0;
            end
         end
         default: state_p0 = SEARCH;
      endcase
   end

   // Stage p1: history, window, FSM and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_p1 <= '0;
      end else if (tx_valid_i) begin
         hist_p1 <= {hist_p1[MAX_LAT-2:0], tx_bit_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt_p1 <= '0;
         win_err_p1 <= '0;
      end else if (rx_valid_i) begin
         if (win_close_p0) begin
            win_cnt_p1 <= '0;
            win_err_p1 <= '0;
         end else begin
            win_cnt_p1 <= win_cnt_p1 + WIN_W'(1);
            win_err_p1 <= win_err_p0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1 <= SEARCH;
         lat_p1   <= '0;
      end else begin
         state_p1 <= state_p0;
         lat_p1   <= lat_p0;
      end
   end

   // clear_i wins over a same-cycle count; that bit is dropped
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         bit_ct_p1 <= '0;
         err_ct_p1 <= '0;
         sat_p1    <= 1'b0;
      end else if (count_p0) begin
         bit_ct_p1 <= bit_ct_p0;
         err_ct_p1 <= err_ct_p0;
         sat_p1    <= sat_p1 | (&bit_ct_p0) | (&err_ct_p0);
      end
   end

   assign locked_o  = (state_p1 == LOCKED);
   assign latency_o = lat_p1;
   assign bit_ct_o  = bit_ct_p1;
   assign err_ct_o  = err_ct_p1;
   assign sat_o     = sat_p1;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Directed bench for viterbi_ber_monitor: PRBS-15 loopback with rx = tx delayed by latency 5.
module tb_viterbi_ber_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i;
   logic        locked_o, sat_o;
   logic [5:0]  latency_o;
   logic [31:0] bit_ct_o, err_ct_o;
   logic        s_locked, s_sat;
   logic [5:0]  s_lat;
   logic [3:0]  s_bit, s_err;

   int checks = 0;
   int failures = 0;
   logic p [0:1023];
   int tx_idx = 0;
   int rx_idx = 0;

   viterbi_ber_monitor dut (
      .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
      .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
      .locked_o(locked_o), .latency_o(latency_o), .bit_ct_o(bit_ct_o),
      .err_ct_o(err_ct_o), .sat_o(sat_o)
   );

   viterbi_ber_monitor #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
      .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
      .locked_o(s_locked), .latency_o(s_lat), .bit_ct_o(s_bit),
      .err_ct_o(s_err), .sat_o(s_sat)
   );

   task automatic gen_prbs(input logic [14:0] seed);
      logic [14:0] st;
      st = seed;
      for (int i = 0; i < 1024; i++) begin
         p[i] = st[14];
         st = {st[13:0], st[14] ^ st[13]};
      end
   endtask

   // errors a trial latency l would see in its window when the true latency is 5
   function automatic int win_errs(input int base, input int l);
      int e;
      e = 0;
      for (int j = 0; j < 32; j++) begin
         int n;
         n = base + 32 * l + j;
         e += int'(p[n] ^ p[n + 5 - l]);
      end
      return e;
   endfunction

   task automatic cyc(input bit tv, input bit rv, input bit inv, input bit clr);
      tx_valid_i = tv;
      tx_bit_i   = tv ? p[tx_idx] : 1'b0;
      rx_valid_i = rv;
      rx_bit_i   = rv ? (p[rx_idx] ^ inv) : 1'b0;
      clear_i    = clr;
      @(posedge clk);
      #1;
      if (tv) tx_idx++;
      if (rv) rx_idx++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      tx_idx = 0;
      rx_idx = 0;
   endtask

   task automatic fill_and_search(input bit verbose);
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 192; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0);
         if (verbose) begin
            checks++;
            if (locked_o !== (k == 192)) begin
               failures++;
               $display("FAIL search_locked k=%0d: got %0d want %0d", k, locked_o, (k == 192));
            end
            checks++;
            if (latency_o !== 6'((k / 32 > 5) ? 5 : k / 32)) begin
               failures++;
               $display("FAIL search_latency k=%0d: got %0d want %0d", k, latency_o,
                        (k / 32 > 5) ? 5 : k / 32);
            end
         end
      end
      checks++;
      if (locked_o !== 1'b1 || latency_o !== 6'd5 || bit_ct_o !== 32'd0 || err_ct_o !== 32'd0) begin
         failures++;
         $display("FAIL lock_state: got locked=%0d lat=%0d bit=%0d err=%0d want 1 5 0 0",
                  locked_o, latency_o, bit_ct_o, err_ct_o);
      end
   endtask

   task automatic test_reset();
      do_reset(3);
      checks++;
      if (locked_o !== 1'b0 || latency_o !== 6'd0 || bit_ct_o !== 32'd0 ||
          err_ct_o !== 32'd0 || sat_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %0d %0d %0d %0d %0d want all 0",
                  locked_o, latency_o, bit_ct_o, err_ct_o, sat_o);
      end
      checks++;
      if (s_locked !== 1'b0 || s_bit !== 4'd0 || s_err !== 4'd0 || s_sat !== 1'b0) begin
         failures++;
         $display("FAIL reset_small: got %0d %0d %0d %0d want all 0", s_locked, s_bit, s_err, s_sat);
      end
      repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (locked_o !== 1'b0 || latency_o !== 6'd0 || bit_ct_o !== 32'd0 ||
          err_ct_o !== 32'd0 || sat_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got %0d %0d %0d %0d %0d want all 0",
                  locked_o, latency_o, bit_ct_o, err_ct_o, sat_o);
      end
   endtask

   task automatic test_lock_search();
      fill_and_search(1'b1);
   endtask

   task automatic test_counting();
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, (i == 10 || i == 11), 1'b0);
      checks++;
      if (bit_ct_o !== 32'd100) begin
         failures++;
         $display("FAIL count_bits: got %0d want 100", bit_ct_o);
      end
      checks++;
      if (err_ct_o !== 32'd2) begin
         failures++;
         $display("FAIL count_errs: got %0d want 2", err_ct_o);
      end
      checks++;
      if (sat_o !== 1'b0 || locked_o !== 1'b1) begin
         failures++;
         $display("FAIL count_flags: got sat=%0d locked=%0d want 0 1", sat_o, locked_o);
      end
      checks++;
      if (s_bit !== 4'd15 || s_err !== 4'd2 || s_sat !== 1'b1) begin
         failures++;
         $display("FAIL count_small: got bit=%0d err=%0d sat=%0d want 15 2 1", s_bit, s_err, s_sat);
      end
   endtask

   task automatic test_clear();
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (bit_ct_o !== 32'd0 || err_ct_o !== 32'd0 || sat_o !== 1'b0) begin
         failures++;
         $display("FAIL clear_counts: got bit=%0d err=%0d sat=%0d want 0 0 0", bit_ct_o, err_ct_o, sat_o);
      end
      checks++;
      if (locked_o !== 1'b1 || latency_o !== 6'd5) begin
         failures++;
         $display("FAIL clear_fsm: got locked=%0d lat=%0d want 1 5", locked_o, latency_o);
      end
      checks++;
      if (s_bit !== 4'd0 || s_err !== 4'd0 || s_sat !== 1'b0) begin
         failures++;
         $display("FAIL clear_small: got %0d %0d %0d want 0 0 0", s_bit, s_err, s_sat);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bit_ct_o !== 32'd1 || err_ct_o !== 32'd0) begin
         failures++;
         $display("FAIL clear_resume: got bit=%0d err=%0d want 1 0", bit_ct_o, err_ct_o);
      end
   endtask

   task automatic test_saturation();
      do_reset(2);
      checks++;
      if (locked_o !== 1'b0 || latency_o !== 6'd0 || bit_ct_o !== 32'd0) begin
         failures++;
         $display("FAIL midop_reset: got locked=%0d lat=%0d bit=%0d want 0 0 0", locked_o, latency_o, bit_ct_o);
      end
      fill_and_search(1'b0);
      repeat (20) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (s_bit !== 4'd15 || s_err !== 4'd15 || s_sat !== 1'b1) begin
         failures++;
         $display("FAIL sat_small: got bit=%0d err=%0d sat=%0d want 15 15 1", s_bit, s_err, s_sat);
      end
      checks++;
      if (bit_ct_o !== 32'd20 || err_ct_o !== 32'd20 || sat_o !== 1'b0) begin
         failures++;
         $display("FAIL sat_wide: got bit=%0d err=%0d sat=%0d want 20 20 0", bit_ct_o, err_ct_o, sat_o);
      end
      repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (s_bit !== 4'd15 || s_err !== 4'd15 || s_sat !== 1'b1) begin
         failures++;
         $display("FAIL sat_sticky: got bit=%0d err=%0d sat=%0d want 15 15 1", s_bit, s_err, s_sat);
      end
      checks++;
      if (bit_ct_o !== 32'd25 || err_ct_o !== 32'd20) begin
         failures++;
         $display("FAIL sat_wide_cont: got bit=%0d err=%0d want 25 20", bit_ct_o, err_ct_o);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (s_sat !== 1'b0 || s_bit !== 4'd0 || s_err !== 4'd0 || sat_o !== 1'b0) begin
         failures++;
         $display("FAIL sat_clear: got sat=%0d bit=%0d err=%0d want 0 0 0", s_sat, s_bit, s_err);
      end
   endtask

   task automatic test_loss();
      do_reset(2);
      fill_and_search(1'b0);
      repeat (31) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (locked_o !== 1'b1) begin
         failures++;
         $display("FAIL loss_early: got locked=%0d want 1", locked_o);
      end
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef BER_LOSS_EN
      checks++;
      if (locked_o !== 1'b0 || latency_o !== 6'd0) begin
         failures++;
         $display("FAIL loss_drop: got locked=%0d lat=%0d want 0 0", locked_o, latency_o);
      end
      checks++;
      if (err_ct_o !== 32'd32 || bit_ct_o !== 32'd32) begin
         failures++;
         $display("FAIL loss_held: got err=%0d bit=%0d want 32 32", err_ct_o, bit_ct_o);
      end
      for (int k = 1; k <= 192; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0);
         checks++;
         if (locked_o !== (k == 192)) begin
            failures++;
            $display("FAIL relock_locked k=%0d: got %0d want %0d", k, locked_o, (k == 192));
         end
      end
      checks++;
      if (latency_o !== 6'd5 || err_ct_o !== 32'd32 || bit_ct_o !== 32'd32) begin
         failures++;
         $display("FAIL relock_state: got lat=%0d err=%0d bit=%0d want 5 32 32", latency_o, err_ct_o, bit_ct_o);
      end
`else
      checks++;
      if (locked_o !== 1'b1 || latency_o !== 6'd5) begin
         failures++;
         $display("FAIL noloss_locked: got locked=%0d lat=%0d want 1 5", locked_o, latency_o);
      end
      checks++;
      if (err_ct_o !== 32'd32 || bit_ct_o !== 32'd32) begin
         failures++;
         $display("FAIL noloss_counts: got err=%0d bit=%0d want 32 32", err_ct_o, bit_ct_o);
      end
`endif
   endtask

   initial begin
      logic [14:0] seed;
      bit good;
      rst = 1'b0; tx_valid_i = 1'b0; tx_bit_i = 1'b0;
      rx_valid_i = 1'b0; rx_bit_i = 1'b0; clear_i = 1'b0;
      seed = 15'h1ACE;
      good = 1'b0;
      // choose a PRBS phase where no wrong trial latency looks clean
      for (int t = 0; t < 64 && !good; t++) begin
         gen_prbs(seed);
         good = 1'b1;
         for (int b = 0; b < 2; b++)
            for (int l = 0; l < 5; l++)
               if (win_errs(b * 224, l) <= 2) good = 1'b0;
         if (!good) seed = seed + 15'd97;
      end
      if (!good) begin
         $display("FAIL seed_select: no usable PRBS seed found");
         $fatal(1, "no usable seed");
      end
      test_reset();
      test_lock_search();
      test_counting();
      test_clear();
      test_saturation();
      test_loss();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
